// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The IFQ_STATS_EN build option changes only the top module, not this package.
package ifq_pkg;

    localparam int IFQ_PC_W    = 16;
    localparam int IFQ_INSTR_W = 32;
    localparam int IFQ_PC_STEP = 4;

    // One queue entry: the fetch address and the word IM returned for it.
    typedef struct packed {
        logic [IFQ_PC_W-1:0]    pc;
        logic [IFQ_INSTR_W-1:0] instr;
    } ifq_entry_t;

    // Forces a byte address onto a word boundary.
    function automatic logic [IFQ_PC_W-1:0] ifq_align(input logic [IFQ_PC_W-1:0] addr);
        return addr & ~IFQ_PC_W'(3);
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries.
// Pointers wrap modulo DEPTH (a power of two). Flush empties the queue in one cycle.
// The IFQ_STATS_EN build option does not affect this module.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = ifq_entry_t,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    output T                 head,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    T                 mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Never push into a full queue or pop an empty one, whatever the caller does.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && (count != CNT_W'(DEPTH));

    // Track the read/write pointers and the occupancy.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every read sees the pre-edge value.
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Write the pushed entry into storage.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; count alone decides which slots hold valid data.
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction fetch unit: issues sequential word reads to IM, absorbs the
// 1-cycle SRAM latency, and queues {pc, instr} pairs for decode.
// A redirect flushes the queue and restarts fetch at the new address.
// Build option IFQ_STATS_EN adds saturating issue and empty-cycle counters.
module if_prefetch_queue
    import ifq_pkg::*;
#(
    parameter int                  DEPTH    = 4,
    parameter logic [IFQ_PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   im_ceb,
    output logic [IFQ_PC_W-1:0]    im_addr,
    input  logic [IFQ_INSTR_W-1:0] im_rdata,
    input  logic                   redirect_valid,
    input  logic [IFQ_PC_W-1:0]    redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IFQ_PC_W-1:0]    out_pc,
    output logic [IFQ_INSTR_W-1:0] out_instr
`ifdef IFQ_STATS_EN
    ,
    output logic [31:0]            stat_fetch_cnt,
    output logic [31:0]            stat_empty_cnt
`endif
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int CRED_W = CNT_W + 1;

    logic [IFQ_PC_W-1:0] fetch_pc;
    logic [IFQ_PC_W-1:0] inflight_pc;
    logic                inflight_v;
    logic [CNT_W-1:0]    q_count;
    logic [CRED_W-1:0]   credit;
    logic                issue;
    logic                push;
    logic                pop;
    ifq_entry_t          push_entry;
    ifq_entry_t          head;

    // Issue only when the queue can hold every outstanding word; a same-cycle pop earns no credit.
    always_comb begin
        // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
        credit = CRED_W'(q_count) + CRED_W'(inflight_v);
        issue  = !rst && !redirect_valid && (credit < CRED_W'(DEPTH));
    end

    assign im_ceb     = !issue;
    assign im_addr    = rst ? RESET_PC : fetch_pc;

    assign out_valid  = (q_count != '0);
    assign pop        = out_valid && out_ready && !redirect_valid;
    assign push       = inflight_v && !redirect_valid && !rst;
    assign push_entry = '{pc: inflight_pc, instr: im_rdata};
    assign out_pc     = head.pc;
    assign out_instr  = head.instr;

    // Advance the fetch address and remember which address the pending IM read belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight_v  <= 1'b0;
            inflight_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc    <= ifq_align(redirect_pc);
            inflight_v  <= 1'b0;
        end else begin
            inflight_v <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + IFQ_PC_W'(IFQ_PC_STEP);
                inflight_pc <= fetch_pc;
            end
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .T     (ifq_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (q_count)
    );

`ifdef IFQ_STATS_EN
    // Saturating counters of IM issues and of cycles with nothing to offer decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetch_cnt <= '0;
            stat_empty_cnt <= '0;
        end else begin
            if (issue && (stat_fetch_cnt != '1))      stat_fetch_cnt <= stat_fetch_cnt + 32'd1;
            if (!out_valid && (stat_empty_cnt != '1)) stat_empty_cnt <= stat_empty_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with a 1-cycle-latency IM model.
// Define IFQ_STATS_EN when building to also exercise the statistics counters.
module tb_if_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_ceb;
    logic [15:0] im_addr;
    logic [31:0] im_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [31:0] out_instr;
`ifdef IFQ_STATS_EN
    logic [31:0] stat_fetch_cnt;
    logic [31:0] stat_empty_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    if_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .im_ceb         (im_ceb),
        .im_addr        (im_addr),
        .im_rdata       (im_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
`ifdef IFQ_STATS_EN
        ,
        .stat_fetch_cnt (stat_fetch_cnt),
        .stat_empty_cnt (stat_empty_cnt)
`endif
    );

    // IM contents are a fixed function of the word address, so any mix-up shows in the data.
    function automatic logic [31:0] instr_at(input logic [15:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    // Synchronous-read IM: data appears the cycle after a read is issued.
    always @(posedge clk) begin
        if (!im_ceb) im_rdata <= instr_at({im_addr[15:2], 2'b00});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic expect_head(input string tag, input logic [15:0] pc);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_pc"}, 32'(out_pc), 32'(pc));
        check({tag, "_instr"}, out_instr, instr_at(pc));
    endtask

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive this cycle's inputs and let combinational outputs settle.
    task automatic set_in(input logic r, input logic rv, input logic [15:0] rpc, input logic rdy);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        out_ready      = 1'b0;

        // Reset state.
        for (int i = 0; i < 2; i++) begin
            tick();
            set_in(1'b1, 1'b0, 16'h0000, 1'b0);
            check("rst_ceb", 32'(im_ceb), 32'd1);
            check("rst_valid", 32'(out_valid), 32'd0);
            check("rst_addr", 32'(im_addr), 32'h0000);
        end

        // Stream from reset: first head on the third cycle, then one per cycle.
        for (int k = 0; k < 10; k++) begin
            tick();
            set_in(1'b0, 1'b0, 16'h0000, 1'b1);
            check("s1_ceb", 32'(im_ceb), 32'd0);
            check("s1_addr", 32'(im_addr), 32'(4 * k));
            if (k < 2) check("s1_early_valid", 32'(out_valid), 32'd0);
            else       expect_head("s1", 16'(4 * (k - 2)));
        end

        // Decode stalls: the head stays 0x20, issue stops once 4 words are owed to the queue.
        for (int i = 0; i < 20; i++) begin
            tick();
            set_in(1'b0, 1'b0, 16'h0000, 1'b0);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_pc", 32'(out_pc), 32'h0020);
            check("stall_ceb", 32'(im_ceb), (i >= 2) ? 32'd1 : 32'd0);
        end

        // Release: entries come out in order with no gap or loss.
        for (int i = 0; i < 8; i++) begin
            tick();
            set_in(1'b0, 1'b0, 16'h0000, 1'b1);
            if (i == 0) check("rel_full_ceb", 32'(im_ceb), 32'd1);
            expect_head("rel", 16'(16'h0020 + 4 * i));
        end

        // Redirect to an unaligned target while streaming.
        tick();
        set_in(1'b0, 1'b1, 16'h0102, 1'b1);
        check("rd_ceb", 32'(im_ceb), 32'd1);
        tick();
        set_in(1'b0, 1'b0, 16'h0000, 1'b1);
        check("rd_t1_valid", 32'(out_valid), 32'd0);
        check("rd_t1_ceb", 32'(im_ceb), 32'd0);
        check("rd_t1_addr", 32'(im_addr), 32'h0100);
        tick();
        set_in(1'b0, 1'b0, 16'h0000, 1'b1);
        check("rd_t2_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            set_in(1'b0, 1'b0, 16'h0000, 1'b1);
            expect_head("rd", 16'(16'h0100 + 4 * i));
        end

        // Back-to-back redirects with out_ready high: only the last target is streamed.
        tick();
        set_in(1'b0, 1'b1, 16'h0200, 1'b1);
        tick();
        set_in(1'b0, 1'b1, 16'h0300, 1'b1);
        check("rr_ceb", 32'(im_ceb), 32'd1);
        check("rr_valid", 32'(out_valid), 32'd0);
        tick();
        set_in(1'b0, 1'b0, 16'h0000, 1'b1);
        check("rr_t1_valid", 32'(out_valid), 32'd0);
        check("rr_t1_addr", 32'(im_addr), 32'h0300);
        check("rr_t1_ceb", 32'(im_ceb), 32'd0);
        tick();
        set_in(1'b0, 1'b0, 16'h0000, 1'b1);
        check("rr_t2_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            set_in(1'b0, 1'b0, 16'h0000, 1'b1);
            expect_head("rr", 16'(16'h0300 + 4 * i));
        end

        // Address wrap-around past 0xFFFC.
        tick();
        set_in(1'b0, 1'b1, 16'hFFF8, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 16'h0000, 1'b1);
        check("wr_t1_valid", 32'(out_valid), 32'd0);
        tick();
        set_in(1'b0, 1'b0, 16'h0000, 1'b1);
        check("wr_t2_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            set_in(1'b0, 1'b0, 16'h0000, 1'b1);
            expect_head("wrap", 16'(16'hFFF8 + 4 * i));
        end

        // Reset mid-stream: in-flight data dropped, fetch restarts at the reset address.
        tick();
        set_in(1'b1, 1'b0, 16'h0000, 1'b1);
        check("mrst_ceb", 32'(im_ceb), 32'd1);
        check("mrst_addr", 32'(im_addr), 32'h0000);
        for (int k = 0; k < 4; k++) begin
            tick();
            set_in(1'b0, 1'b0, 16'h0000, 1'b1);
            if (k < 2) check("mrst_early_valid", 32'(out_valid), 32'd0);
            else       expect_head("mrst", 16'(4 * (k - 2)));
        end

`ifdef IFQ_STATS_EN
        // Statistics: 10 issue cycles, then a held redirect keeps fetch idle and the queue empty.
        tick();
        set_in(1'b1, 1'b0, 16'h0000, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 16'h0000, 1'b1);
        check("st_rst_fetch", stat_fetch_cnt, 32'd0);
        check("st_rst_empty", stat_empty_cnt, 32'd0);
        for (int k = 1; k < 10; k++) begin
            tick();
            set_in(1'b0, 1'b0, 16'h0000, 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            set_in(1'b0, 1'b1, 16'h0000, 1'b1);
        end
        tick();
        set_in(1'b0, 1'b1, 16'h0000, 1'b1);
        check("st_fetch", stat_fetch_cnt, 32'd10);
        check("st_empty", stat_empty_cnt, 32'd6);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
